round_robin_memory_port_arbiter: RTL and testbench
==================================================

// Module: round_robin_memory_port_arbiter
// PURPOSE
//  - Shares one read-write RAM port (e.g. one port of the true dual-port RAM) among REQUESTERS masters.
//  - Per-requester valid/ready request channel; per-requester read response strobe.
//  - Round-robin fairness, optional lock for atomic multi-beat sequences.
//  - Sits between bus-side masters and the memory macro, one instance per RAM port.
// PARAMETERS
//  REQUESTERS      4              number of requesters (>=2)
//  WIDTH           8              data width, matches RAM WIDTH
//  DEPTH           16             RAM depth, matches RAM DEPTH
//  REGISTERED_READ 1              1: read data 1 cycle after access; 0: same cycle (matches RAM)
//  ADDRESS_WIDTH   `CLOG2(DEPTH)  address width
// PORTS
//  clock                 in   1                     single clock, rising edge
//  reset                 in   1                     asynchronous, active-high
//  request_valid         in   REQUESTERS            requester i has an access pending
//  request_ready         out  REQUESTERS            access of requester i accepted this cycle
//  request_write         in   REQUESTERS            1 write, 0 read, per requester
//  request_lock          in   REQUESTERS            keep grant after this access
//  request_address       in   REQUESTERS*ADDRESS_WIDTH  packed, requester i at [i*AW +: AW]
//  request_write_data    in   REQUESTERS*WIDTH      packed, requester i at [i*W +: W]
//  response_valid        out  REQUESTERS            read data valid for requester i
//  response_read_data    out  WIDTH                 shared read data bus
//  memory_access_enable  out  1                     to RAM port access_enable
//  memory_write          out  1                     to RAM port write
//  memory_address        out  ADDRESS_WIDTH         to RAM port address
//  memory_write_data     out  WIDTH                 to RAM port write_data
//  memory_read_data      in   WIDTH                 from RAM port read_data
// BEHAVIOUR
//  - Reset (async, immediate): pointer=0, state=ARBITRATE, lock owner cleared, response_valid=0,
//    response pipeline flushed; in-flight read responses are dropped, never issued after reset.
//  - At most one access per cycle; exactly one request_ready bit high iff memory_access_enable=1.
//  - ready is combinational from valid/state/pointer; transfer = valid[i] & ready[i].
//  - Memory outputs combinational mux of granted requester; access_enable=0 -> other memory outputs
//    are don't-care but driven to granted/zero value (no X).
//  - State ARBITRATE: grant first valid requester scanning pointer, pointer+1, ... wrapping at
//    REQUESTERS-1 -> 0. On transfer by i: pointer <= (i+1) mod REQUESTERS; if request_lock[i]=1
//    -> state LOCKED, owner <= i.
//  - State LOCKED: only owner can be granted; others see ready=0 even if valid. On owner transfer
//    with lock=0 -> ARBITRATE, pointer <= (owner+1) mod REQUESTERS. Owner valid=0 -> stay LOCKED,
//    no access issued.
//  - Read response: REGISTERED_READ=1 -> response_valid[i]=1 exactly 1 cycle after read transfer
//    of i, response_read_data=memory_read_data that cycle. REGISTERED_READ=0 -> response_valid[i]
//    same cycle as transfer (combinational). Back-to-back reads give back-to-back responses.
//  - Writes produce no response. response_valid one-hot or zero. No response backpressure.
//  - Write then read same address in consecutive cycles: read returns new data (RAM ordering).
//  - Valid dropped without ready: no access, pointer unchanged.
// TESTING
//  - Reset: assert reset mid-read (REGISTERED_READ=1) -> response_valid=0 next cycle, pointer=0.
//  - All 4 valid for 8 cycles, no lock -> grants 0,1,2,3,0,1,2,3; one ready per cycle.
//  - Req1 write addr 5 data 0xA5, next cycle req2 read addr 5 -> response_valid=4'b0100 one cycle
//    later with data 0xA5.
//  - Req2 lock=1 for 3 accesses, req0/req3 valid throughout -> grants 2,2,2 then 3,0.
//  - Locked owner idles 2 cycles while req0 valid -> no access, ready=0; then owner lock=0 access.
//  - REGISTERED_READ=0: req3 read addr 0xF holding 0x3C -> response_valid[3] and data 0x3C same cycle.

Source files
------------

// File: rtl/round_robin_memory_port_arbiter.sv
// Round-robin arbiter sharing one RAM read/write port among several requesters,
// with an optional lock that keeps the grant on one requester for multi-beat sequences.
//
// state     | meaning
// ARBITRATE | grant the first valid requester starting at pointer, wrapping around
// LOCKED    | only the lock owner may be granted; other requesters are held off
module round_robin_memory_port_arbiter #(
  parameter int REQUESTERS      = 4,
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 16,
  parameter int REGISTERED_READ = 1,
  parameter int ADDRESS_WIDTH   = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [REQUESTERS-1:0]               request_valid,
  output logic [REQUESTERS-1:0]               request_ready,
  input  logic [REQUESTERS-1:0]               request_write,
  input  logic [REQUESTERS-1:0]               request_lock,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
  input  logic [REQUESTERS*WIDTH-1:0]         request_write_data,
  output logic [REQUESTERS-1:0]               response_valid,
  output logic [WIDTH-1:0]                    response_read_data,
  output logic                                memory_access_enable,
  output logic                                memory_write,
  output logic [ADDRESS_WIDTH-1:0]            memory_address,
  output logic [WIDTH-1:0]                    memory_write_data,
  input  logic [WIDTH-1:0]                    memory_read_data
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic {
    ARBITRATE = 1'b0,
    LOCKED    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pointer_q, pointer_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   next_pointer;
  logic [REQUESTERS-1:0] resp_valid_d;
  int              cand;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARBITRATE;
      pointer_q <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
      owner_q   <= owner_d;
    end
  end

  // Scan downward from the farthest offset so the candidate closest to pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (state_q == LOCKED) begin
      if (request_valid[owner_q]) begin
        grant_valid = 1'b1;
        grant_idx   = owner_q;
      end
    end else begin
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
        cand = int'(pointer_q) + k;
        if (cand >= REQUESTERS) cand = cand - REQUESTERS;
        if (request_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(cand);
        end
      end
    end
  end

  always_comb begin
    request_ready        = '0;
    memory_access_enable = grant_valid;
    memory_write         = 1'b0;
    memory_address       = '0;
    memory_write_data    = '0;
    if (grant_valid) begin
      request_ready[grant_idx] = 1'b1;
      memory_write      = request_write[grant_idx];
      memory_address    = request_address[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      memory_write_data = request_write_data[int'(grant_idx)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    pointer_d    = pointer_q;
    owner_d      = owner_q;
    next_pointer = (grant_idx == PW'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
    if (grant_valid) begin
      pointer_d = next_pointer;
      if (request_lock[grant_idx]) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = ARBITRATE;
      end
    end
  end

  assign resp_valid_d       = request_ready & ~request_write;
  assign response_read_data = memory_read_data;

  generate
    if (REGISTERED_READ != 0) begin : g_registered
      logic [REQUESTERS-1:0] resp_valid_q;
      // Flushed by reset so an in-flight read never produces a late response.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) resp_valid_q <= '0;
        else       resp_valid_q <= resp_valid_d;
      end
      assign response_valid = resp_valid_q;
    end else begin : g_combinational
      assign response_valid = resp_valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_round_robin_memory_port_arbiter.sv
// Randomized and directed bench for the round-robin memory port arbiter; one registered-read
// and one combinational-read instance share the same request inputs.
module tb_round_robin_memory_port_arbiter;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [R-1:0]    request_valid, request_write, request_lock;
  logic [R*AW-1:0] request_address;
  logic [R*W-1:0]  request_write_data;

  logic [R-1:0]  request_ready, response_valid;
  logic [W-1:0]  response_read_data, memory_write_data, memory_read_data;
  logic          memory_access_enable, memory_write;
  logic [AW-1:0] memory_address;

  logic [R-1:0]  request_ready_0, response_valid_0;
  logic [W-1:0]  response_read_data_0, memory_write_data_0, memory_read_data_0;
  logic          memory_access_enable_0, memory_write_0;
  logic [AW-1:0] memory_address_0;

  round_robin_memory_port_arbiter #(.REQUESTERS(R), .WIDTH(W), .DEPTH(D), .REGISTERED_READ(1)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_lock(request_lock),
    .request_address(request_address), .request_write_data(request_write_data),
    .response_valid(response_valid), .response_read_data(response_read_data),
    .memory_access_enable(memory_access_enable), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data));

  round_robin_memory_port_arbiter #(.REQUESTERS(R), .WIDTH(W), .DEPTH(D), .REGISTERED_READ(0)) dut_0 (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready_0),
    .request_write(request_write), .request_lock(request_lock),
    .request_address(request_address), .request_write_data(request_write_data),
    .response_valid(response_valid_0), .response_read_data(response_read_data_0),
    .memory_access_enable(memory_access_enable_0), .memory_write(memory_write_0),
    .memory_address(memory_address_0), .memory_write_data(memory_write_data_0),
    .memory_read_data(memory_read_data_0));

  // RAM macros attached to each instance: registered read and combinational read.
  logic [W-1:0] ram1 [D];
  logic [W-1:0] ram0 [D];
  always @(posedge clock) begin
    if (memory_access_enable) begin
      if (memory_write) ram1[memory_address] <= memory_write_data;
      else              memory_read_data     <= ram1[memory_address];
    end
    if (memory_access_enable_0 && memory_write_0) ram0[memory_address_0] <= memory_write_data_0;
  end
  assign memory_read_data_0 = ram0[memory_address_0];

  // Reference model: memory contents, rotation pointer, lock ownership, pending response.
  logic [W-1:0] m_mem [D];
  int           m_ptr, m_owner, pend_idx;
  bit           m_locked;
  logic [W-1:0] pend_data;

  int total = 0;
  int bad   = 0;

  int           obs_grant;
  logic [R-1:0] obs_ready, obs_rv, obs_rv0;
  logic [W-1:0] obs_rdata, obs_rdata0;
  logic         obs_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    request_valid      = '0;
    request_write      = '0;
    request_lock       = '0;
    request_address    = '0;
    request_write_data = '0;
  endtask

  task automatic set_req(input int i, input bit w, input bit l, input int a, input int d);
    request_valid[i]               = 1'b1;
    request_write[i]               = w;
    request_lock[i]                = l;
    request_address[i*AW +: AW]    = AW'(a);
    request_write_data[i*W +: W]   = W'(d);
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_locked = 0;
    pend_idx = -1;
  endtask

  task automatic cyc();
    int           eg;
    logic [R-1:0] er, erv, erv0;
    logic [AW-1:0] a;
    @(negedge clock);
    #1;
    eg = -1;
    if (m_locked) begin
      if (request_valid[m_owner]) eg = m_owner;
    end else begin
      for (int k = 0; k < R; k++) begin
        int j;
        j = (m_ptr + k) % R;
        if (request_valid[j] && eg < 0) eg = j;
      end
    end
    er = '0;
    if (eg >= 0) er[eg] = 1'b1;

    obs_ready  = request_ready;
    obs_rv     = response_valid;
    obs_rdata  = response_read_data;
    obs_rv0    = response_valid_0;
    obs_rdata0 = response_read_data_0;
    obs_en     = memory_access_enable;
    obs_grant  = -1;
    for (int k = 0; k < R; k++) if (request_ready[k]) obs_grant = k;

    check_eq("ready", 32'(request_ready), 32'(er));
    check_eq("ready_comb_inst", 32'(request_ready_0), 32'(er));
    check_eq("mem_en", 32'(memory_access_enable), 32'(eg >= 0));
    a = '0;
    if (eg >= 0) begin
      a = request_address[eg*AW +: AW];
      check_eq("mem_addr", 32'(memory_address), 32'(a));
      check_eq("mem_write", 32'(memory_write), 32'(request_write[eg]));
      if (request_write[eg])
        check_eq("mem_wdata", 32'(memory_write_data), 32'(request_write_data[eg*W +: W]));
    end

    erv = '0;
    if (pend_idx >= 0) erv[pend_idx] = 1'b1;
    check_eq("resp_valid", 32'(response_valid), 32'(erv));
    if (pend_idx >= 0) check_eq("resp_data", 32'(response_read_data), 32'(pend_data));

    erv0 = '0;
    if (eg >= 0 && !request_write[eg]) erv0[eg] = 1'b1;
    check_eq("resp_valid_comb", 32'(response_valid_0), 32'(erv0));
    if (eg >= 0 && !request_write[eg])
      check_eq("resp_data_comb", 32'(response_read_data_0), 32'(m_mem[a]));

    @(posedge clock);
    #1;
    pend_idx = -1;
    if (eg >= 0) begin
      if (request_write[eg]) m_mem[a] = request_write_data[eg*W +: W];
      else begin
        pend_idx  = eg;
        pend_data = m_mem[a];
      end
      m_ptr = (eg + 1) % R;
      if (request_lock[eg]) begin
        m_locked = 1;
        m_owner  = eg;
      end else begin
        m_locked = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    #12;
    check_eq("reset_resp_valid", 32'(response_valid), 32'h0);
    check_eq("reset_mem_en", 32'(memory_access_enable), 32'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < D; i++) begin
      idle();
      set_req(i % R, 1'b1, 1'b0, i, int'($urandom_range(255)));
      cyc();
    end

    // All requesters valid, no lock: strict rotation.
    for (int i = 0; i < 8; i++) begin
      idle();
      for (int r = 0; r < R; r++) set_req(r, 1'b0, 1'b0, int'($urandom_range(D-1)), 0);
      cyc();
      check_eq("rr_order", 32'(obs_grant), 32'(i % R));
    end

    // Write then read of the same address by different requesters.
    idle(); set_req(1, 1'b1, 1'b0, 5, 8'hA5); cyc();
    idle(); set_req(2, 1'b0, 1'b0, 5, 0);     cyc();
    idle(); cyc();
    check_eq("wr_rd_valid", 32'(obs_rv), 32'h4);
    check_eq("wr_rd_data", 32'(obs_rdata), 32'hA5);

    // Lock sequence by requester 2 while 0 and 3 keep requesting.
    idle(); set_req(1, 1'b0, 1'b0, 0, 0); cyc();
    for (int i = 0; i < 5; i++) begin
      idle();
      set_req(0, 1'b0, 1'b0, 1, 0);
      set_req(3, 1'b0, 1'b0, 2, 0);
      if (i < 3) set_req(2, 1'b0, (i < 2), 3, 0);
      cyc();
      case (i)
        0, 1, 2: check_eq("lock_grant", 32'(obs_grant), 32'd2);
        3:       check_eq("lock_grant", 32'(obs_grant), 32'd3);
        default: check_eq("lock_grant", 32'(obs_grant), 32'd0);
      endcase
    end

    // Locked owner goes idle: nobody else gets the port.
    idle(); set_req(0, 1'b0, 1'b0, 4, 0); set_req(1, 1'b0, 1'b1, 6, 0); cyc();
    check_eq("lock_take", 32'(obs_grant), 32'd1);
    for (int i = 0; i < 2; i++) begin
      idle(); set_req(0, 1'b0, 1'b0, 4, 0); cyc();
      check_eq("lock_idle_ready", 32'(obs_ready), 32'h0);
      check_eq("lock_idle_en", 32'(obs_en), 32'h0);
    end
    idle(); set_req(0, 1'b0, 1'b0, 4, 0); set_req(1, 1'b0, 1'b0, 6, 0); cyc();
    check_eq("lock_release", 32'(obs_grant), 32'd1);
    idle(); set_req(0, 1'b0, 1'b0, 4, 0); cyc();
    check_eq("after_release", 32'(obs_grant), 32'd0);

    // Combinational-read instance returns data in the access cycle.
    idle(); set_req(3, 1'b1, 1'b0, 15, 8'h3C); cyc();
    idle(); set_req(3, 1'b0, 1'b0, 15, 0);     cyc();
    check_eq("comb_rv", 32'(obs_rv0), 32'h8);
    check_eq("comb_data", 32'(obs_rdata0), 32'h3C);

    // Reset while a registered read is in flight.
    idle(); set_req(1, 1'b0, 1'b0, 3, 0); cyc();
    reset = 1'b1;
    #1;
    check_eq("rst_mid_read_rv", 32'(response_valid), 32'h0);
    model_reset();
    #1 reset = 1'b0;
    idle();
    for (int r = 0; r < R; r++) set_req(r, 1'b0, 1'b0, r, 0);
    cyc();
    check_eq("rst_pointer", 32'(obs_grant), 32'd0);

    for (int n = 0; n < 600; n++) begin
      idle();
      for (int r = 0; r < R; r++) begin
        if ($urandom_range(1) == 1)
          set_req(r, $urandom_range(1) == 1, $urandom_range(3) == 0,
                  int'($urandom_range(D-1)), int'($urandom_range(255)));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
